spec_free_list: RTL
===================

SPEC_FREE_LIST -- requirements
Module: spec_free_list

Interface
REQ-001 SHALL have parameter PHY_REG_NUM, default 64: number of physical registers and free-list entries.
REQ-002 SHALL use `DECODE_WIDTH as the allocation lane count and `COMMIT_WIDTH as the free lane count, both from config.svh.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1: pipeline flush; restore state to the architectural free list.
REQ-006 SHALL have port alloc_valid_i, input, `DECODE_WIDTH: per-lane request for one destination preg.
REQ-007 SHALL have port alloc_ready_o, output, 1: the list can serve any request pattern this cycle.
REQ-008 SHALL have port alloc_preg_o, output, `DECODE_WIDTH x clog2(PHY_REG_NUM): allocated preg per lane.
REQ-009 SHALL have port free_valid_i, input, `COMMIT_WIDTH: per-lane committed release of an old preg.
REQ-010 SHALL have port free_preg_i, input, `COMMIT_WIDTH x clog2(PHY_REG_NUM): pregs being released.
REQ-011 SHALL have port arch_head_i, input, clog2(PHY_REG_NUM): committed head, combinational next-value from the architectural free list.
REQ-012 SHALL have port arch_tail_i, input, clog2(PHY_REG_NUM): committed tail, same-cycle next-value.
REQ-013 SHALL have port arch_cnt_i, input, clog2(PHY_REG_NUM+1): committed free count, same-cycle next-value.
REQ-014 SHALL have port free_cnt_o, output, clog2(PHY_REG_NUM+1): current speculative free count (registered).

Function
REQ-015 SHALL hold a circular buffer of PHY_REG_NUM preg ids with registered head, tail and cnt; pointers wrap modulo PHY_REG_NUM.
REQ-016 SHALL drive alloc_ready_o = (cnt >= `DECODE_WIDTH) & ~flush_i, from registered cnt only, with no dependence on alloc_valid_i.
REQ-017 SHALL drive alloc_preg_o[i] = buf[head + number of set alloc_valid_i bits below lane i], combinationally in the same cycle; invalid lanes carry don't-care.
REQ-018 SHALL define alloc fire = alloc_ready_o & |alloc_valid_i; on fire head advances by popcount(alloc_valid_i); valid lanes need not be contiguous.
REQ-019 SHALL write free_preg_i[j] to buf[tail + number of set free_valid_i bits below lane j] for each valid lane j; tail advances by popcount(free_valid_i); frees are never back-pressured.
REQ-020 SHALL update cnt_next = cnt + popcount(free) - (fire ? popcount(alloc) : 0), with width clog2(PHY_REG_NUM+1) and no wrap.
REQ-021 SHALL handle simultaneous alloc and free in one cycle with the rule in REQ-020; allocation reads the pre-write buffer contents, so a preg freed this cycle cannot be handed out until the next cycle.
REQ-022 SHALL, on flush_i, load head<=arch_head_i, tail<=arch_tail_i, cnt<=arch_cnt_i; suppress allocation in that cycle; and still perform that cycle's buffer writes.
REQ-023 SHALL assert, in simulation only, that cnt never exceeds PHY_REG_NUM and that allocation never occurs with cnt < popcount(alloc_valid_i).

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set head=0, tail=0, cnt=PHY_REG_NUM and buf[i]=i for all i, matching the architectural free list's reset state.
REQ-025 SHALL drive alloc_ready_o=1 and free_cnt_o=PHY_REG_NUM in the first cycle after reset deasserts (for PHY_REG_NUM >= `DECODE_WIDTH).
REQ-026 SHALL give rst priority over flush_i, alloc and free when they coincide; no write occurs that cycle.

Structure
REQ-027 SHALL take the preg index typedef (width clog2(PHY_REG_NUM)) and the PHY_REG_NUM constant from the shared pipeline package, common to the rename table and the architectural free list.
REQ-028 SHALL implement lane-offset prefix counting in one reusable sub-module, prefix_popcount, instantiated once for the alloc lanes and once for the free lanes.
REQ-029 SHALL implement the buffer as flip-flops with `DECODE_WIDTH read ports and `COMMIT_WIDTH write ports; no SRAM macro.

Verification (PHY_REG_NUM=64, DECODE=COMMIT=4)
REQ-030 SHALL test: reset, then alloc_valid_i=4'b1011 -> alloc_preg_o lanes 0,1,3 = 0,1,2; next cycle head=3, free_cnt_o=61.
REQ-031 SHALL test: 15 full-width allocs (cnt=4), then one more -> ready=1, pregs 60..63, cnt=0; next cycle ready=0, and a request with no fire leaves head unchanged.
REQ-032 SHALL test: cnt=0 with free_valid_i=4'b0101, free_preg_i lanes 0,2=7,9 -> buf[0]=7, buf[1]=9 (tail wrapped), cnt=2, ready stays 0.
REQ-033 SHALL test: simultaneous 4 allocs and 4 frees at cnt=4 -> cnt stays 4, and the allocated pregs are the old entries, not the pregs just freed.
REQ-034 SHALL test: flush_i with alloc_valid_i=4'hF and arch_head_i=10, arch_tail_i=10, arch_cnt_i=64 -> no allocation; next cycle head=10, cnt=64, ready=1.
REQ-035 SHALL test: rst asserted during a cycle that also has flush, alloc and free -> next state equals the REQ-024 reset state exactly.

Source files
------------

// File: rtl/spec_free_list_pkg.sv
// Shared pipeline package for the rename stage.
// Holds the physical register file size, the preg index type used by the
// rename table, the architectural free list and the speculative free list,
// and a small modular-add helper for circular pointers.
// Lane counts are compile-time macros; defaults are given here when the
// build does not supply them.

`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package spec_free_list_pkg;

  localparam int PHY_REG_NUM = 64;
  localparam int PREG_W      = $clog2(PHY_REG_NUM);
  localparam int CNT_W       = $clog2(PHY_REG_NUM + 1);

  typedef logic [PREG_W-1:0] preg_t;

  // base + off modulo n, for base < n and off <= n (one correction suffices).
  function automatic int unsigned wrap_add(int unsigned base, int unsigned off,
                                           int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/spec_free_list_prefix_popcount.sv
// prefix_popcount: for each lane i, the number of set valid bits in lanes
// strictly below i (the lane's slot offset), plus the total popcount.
// Ports:
//   valid  [N]          per-lane request bits
//   offset [N] x OW     exclusive prefix count per lane
//   total  OW           popcount of all lanes

`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

module prefix_popcount #(
  parameter int N  = 4,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]         valid,
  output logic [N-1:0][OW-1:0] offset,
  output logic [OW-1:0]        total
);

  logic [OW-1:0] run;

  always_comb begin
    run    = '0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = run;
      run       = run + OW'(valid[i]);
    end
    total = run;
  end

endmodule

// File: rtl/spec_free_list.sv
// spec_free_list: speculative free list of physical registers.
// A circular buffer of preg ids with registered head/tail/count. Decode lanes
// pop pregs from head (non-contiguous valid lanes are packed), commit lanes
// push released pregs at tail. A flush reloads the pointers and count from
// the architectural free list's next-state values.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         restore pointers/count from arch_*_i
//   alloc_valid_i   per-lane allocation request
//   alloc_ready_o   enough entries for any request pattern (registered count)
//   alloc_preg_o    allocated preg per lane (same cycle)
//   free_valid_i    per-lane release
//   free_preg_i     released preg per lane
//   arch_head_i, arch_tail_i, arch_cnt_i   committed state (next-value)
//   free_cnt_o      current speculative free count

`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

module spec_free_list
  import spec_free_list_pkg::wrap_add;
#(
  parameter int PHY_REG_NUM = spec_free_list_pkg::PHY_REG_NUM
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              flush_i,
  input  logic [`DECODE_WIDTH-1:0]                          alloc_valid_i,
  output logic                                              alloc_ready_o,
  output logic [`DECODE_WIDTH-1:0][$clog2(PHY_REG_NUM)-1:0] alloc_preg_o,
  input  logic [`COMMIT_WIDTH-1:0]                          free_valid_i,
  input  logic [`COMMIT_WIDTH-1:0][$clog2(PHY_REG_NUM)-1:0] free_preg_i,
  input  logic [$clog2(PHY_REG_NUM)-1:0]                    arch_head_i,
  input  logic [$clog2(PHY_REG_NUM)-1:0]                    arch_tail_i,
  input  logic [$clog2(PHY_REG_NUM+1)-1:0]                  arch_cnt_i,
  output logic [$clog2(PHY_REG_NUM+1)-1:0]                  free_cnt_o
);

  localparam int DW  = `DECODE_WIDTH;
  localparam int CW  = `COMMIT_WIDTH;
  localparam int PW  = $clog2(PHY_REG_NUM);
  localparam int NW  = $clog2(PHY_REG_NUM + 1);
  localparam int AOW = $clog2(DW + 1);
  localparam int FOW = $clog2(CW + 1);

  logic [PW-1:0] buf_reg [PHY_REG_NUM];
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [NW-1:0] cnt_reg, cnt_next;

  logic [DW-1:0][AOW-1:0] alloc_off;
  logic [AOW-1:0]         alloc_total;
  logic [CW-1:0][FOW-1:0] free_off;
  logic [FOW-1:0]         free_total;
  logic [CW-1:0][PW-1:0]  waddr;
  logic                   fire;

  prefix_popcount #(.N(DW), .OW(AOW)) u_alloc_pop (
    .valid  (alloc_valid_i),
    .offset (alloc_off),
    .total  (alloc_total)
  );

  prefix_popcount #(.N(CW), .OW(FOW)) u_free_pop (
    .valid  (free_valid_i),
    .offset (free_off),
    .total  (free_total)
  );

  // Ready looks only at the registered count so it never loops back through
  // the decode lanes' valid logic.
  assign alloc_ready_o = (cnt_reg >= NW'(DW)) & ~flush_i;
  assign fire          = alloc_ready_o & (|alloc_valid_i);
  assign free_cnt_o    = cnt_reg;

  genvar gi;

  // Read ports see the buffer before this cycle's writes, so a preg freed
  // now is only handed out from the next cycle on.
  generate
    for (gi = 0; gi < DW; gi++) begin : g_rd
      assign alloc_preg_o[gi] =
        buf_reg[PW'(wrap_add(32'(head_reg), 32'(alloc_off[gi]), PHY_REG_NUM))];
    end
    for (gi = 0; gi < CW; gi++) begin : g_wa
      assign waddr[gi] =
        PW'(wrap_add(32'(tail_reg), 32'(free_off[gi]), PHY_REG_NUM));
    end
  endgenerate

  always_comb begin
    head_next = PW'(wrap_add(32'(head_reg), fire ? 32'(alloc_total) : 32'd0,
                             PHY_REG_NUM));
    tail_next = PW'(wrap_add(32'(tail_reg), 32'(free_total), PHY_REG_NUM));
    cnt_next  = cnt_reg + NW'(free_total) - (fire ? NW'(alloc_total) : NW'(0));
    if (flush_i) begin
      head_next = arch_head_i;
      tail_next = arch_tail_i;
      cnt_next  = arch_cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
      cnt_reg  <= NW'(PHY_REG_NUM);
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Buffer writes happen even in a flush cycle: they are committed releases
  // already reflected in the architectural state being restored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        buf_reg[i] <= PW'(i);
      end
    end else begin
      for (int j = 0; j < CW; j++) begin
        if (free_valid_i[j]) begin
          buf_reg[waddr[j]] <= free_preg_i[j];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_reg <= NW'(PHY_REG_NUM));
      assert (!fire || (cnt_reg >= NW'(alloc_total)));
    end
  end
`endif

endmodule
